// File: rtl/maxpool_relu_stream.sv
`default_nettype none
// maxpool_relu_stream: streaming 2x2/stride-2 max-pool with optional ReLU on a binary32 raster stream.
// Even rows fold into a half-row line buffer; odd rows complete the window and emit one result.
module maxpool_relu_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_W       = 28,
  parameter int IN_H       = 28,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int CW   = $clog2(IN_W);
  localparam int RW   = $clog2(IN_H);
  localparam int LB_N = IN_W / 2;
  localparam int MSB  = DATA_WIDTH - 1;

  generate
    if ((IN_W % 2) != 0) begin : g_bad_in_w
      $error("maxpool_relu_stream: IN_W must be even");
    end
    if ((IN_H % 2) != 0) begin : g_bad_in_h
      $error("maxpool_relu_stream: IN_H must be even");
    end
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("maxpool_relu_stream: DATA_WIDTH is fixed at 32");
    end
  endgenerate

  typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} phase_t;

  phase_t                phase, phase_nxt;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  accept, col_last, row_last, win_done;
  logic [DATA_WIDTH-1:0] h, pair_max, win_max, result;
  logic [DATA_WIDTH-1:0] lb [LB_N];

  // Sign-magnitude ordering on raw bits; ties (and +0 vs -0 handled by sign rule) keep a.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    r = a;
    if (a[MSB] != b[MSB])
      r = a[MSB] ? b : a;
    else if (!a[MSB])
      r = (b[MSB-1:0] > a[MSB-1:0]) ? b : a;
    else
      r = (b[MSB-1:0] < a[MSB-1:0]) ? b : a;
    return r;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == CW'(IN_W - 1));
  assign row_last = (row == RW'(IN_H - 1));
  assign win_done = accept && col[0] && (phase == ROW_ODD);
  assign pair_max = fmax(h, in_data);
  assign win_max  = fmax(lb[col[CW-1:1]], pair_max);
  assign result   = (RELU_EN && win_max[MSB]) ? '0 : win_max;

  always_comb begin
    phase_nxt = phase;
    if (accept && col_last)
      phase_nxt = (phase == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= ROW_EVEN;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      phase <= phase_nxt;
      if (accept) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last)
          row <= row_last ? '0 : row + 1'b1;
      end
      // A new result wins over a simultaneous out-beat, keeping out_valid high.
      if (win_done) begin
        out_data  <= result;
        out_valid <= 1'b1;
        out_last  <= row_last && col_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Datapath storage needs no reset: every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (accept && !col[0])
      h <= in_data;
    if (accept && col[0] && (phase == ROW_EVEN))
      lb[col[CW-1:1]] <= pair_max;
  end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_relu_stream.sv
`default_nettype none
// tb_maxpool_relu_stream: randomized self-checking bench; two instances (ReLU on/off) share one stream.
module tb_maxpool_relu_stream;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_last;
  logic        in_ready_n, out_valid_n, out_last_n;
  logic [31:0] out_data, out_data_n;

  int n_checks = 0;
  int n_fail = 0;
  int ready_mode = 0;
  int in_ready_low = 0;

  logic [31:0] frame [NPIX];
  logic [31:0] cap_r[$], cap_n[$], exp_r[$], exp_n[$];
  logic        cap_l[$];

  maxpool_relu_stream #(.DATA_WIDTH(32), .IN_W(W), .IN_H(H), .RELU_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

  maxpool_relu_stream #(.DATA_WIDTH(32), .IN_W(W), .IN_H(H), .RELU_EN(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .out_last(out_last_n));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      cap_r.push_back(out_data);
      cap_n.push_back(out_data_n);
      cap_l.push_back(out_last);
    end
    if (!in_ready) in_ready_low++;
  end

  // Reference max: real-number ordering via a signed key; +0 beats -0.
  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    if (ka > kb) return a;
    if (kb > ka) return b;
    return a[31] ? b : a;
  endfunction

  function automatic logic [31:0] int2f(input int n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (((n >> b) & 1) == 1) e = b;
    m = (32'(n) << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic build_expected();
    logic [31:0] m;
    for (int i = 0; i < H / 2; i++)
      for (int j = 0; j < W / 2; j++) begin
        m = ref_max(ref_max(frame[2*i*W + 2*j], frame[2*i*W + 2*j + 1]),
                    ref_max(frame[(2*i+1)*W + 2*j], frame[(2*i+1)*W + 2*j + 1]));
        exp_n.push_back(m);
        exp_r.push_back(m[31] ? 32'h0 : m);
      end
  endtask

  task automatic clear_queues();
    cap_r.delete(); cap_n.delete(); cap_l.delete(); exp_r.delete(); exp_n.delete();
  endtask

  // Called aligned at posedge+1; returns aligned at posedge+1.
  task automatic drive_pixels(input int n, input int gap_max);
    int gap, waited;
    for (int i = 0; i < n; i++) begin
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = frame[i];
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 2000) begin @(negedge clk); waited++; end
      if (waited >= 2000) begin
        n_checks++; n_fail++;
        $display("FAIL drive_timeout: pixel %0d never accepted (in_ready stuck at %b)", i, in_ready);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (cap_r.size() < n && t < 20000) begin @(posedge clk); t++; end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 8;
    if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_last !== 1'b0)     begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    if (out_data !== 32'h0)    begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid_n !== 1'b0)  begin n_fail++; $display("FAIL reset_nr_out_valid: got %b want 0", out_valid_n); end
    if (out_last_n !== 1'b0)   begin n_fail++; $display("FAIL reset_nr_out_last: got %b want 0", out_last_n); end
    if (out_data_n !== 32'h0)  begin n_fail++; $display("FAIL reset_nr_out_data: got %h want 0", out_data_n); end
    if (in_ready_n !== 1'b1)   begin n_fail++; $display("FAIL reset_nr_in_ready: got %b want 1", in_ready_n); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_const_frame();
    clear_queues();
    ready_mode = 0;
    for (int i = 0; i < NPIX; i++) frame[i] = 32'h43C8_0000;
    build_expected();
    in_ready_low = 0;
    drive_pixels(NPIX, 0);
    wait_outputs(NOUT);
    n_checks += 2;
    if (in_ready_low !== 0)  begin n_fail++; $display("FAIL const_in_ready: low %0d cycles, want 0", in_ready_low); end
    if (cap_r.size() !== NOUT) begin n_fail++; $display("FAIL const_count: got %0d want %0d", cap_r.size(), NOUT); end
    for (int k = 0; k < cap_r.size() && k < NOUT; k++) begin
      n_checks += 2;
      if (cap_r[k] !== 32'h43C8_0000) begin n_fail++; $display("FAIL const_data[%0d]: got %h want 43c80000", k, cap_r[k]); end
      if (cap_l[k] !== (k == NOUT - 1)) begin n_fail++; $display("FAIL const_last[%0d]: got %b want %b", k, cap_l[k], k == NOUT - 1); end
    end
  endtask

  task automatic test_windows();
    clear_queues();
    ready_mode = 1;
    for (int i = 0; i < NPIX; i++) frame[i] = $urandom();
    frame[0] = 32'hBF80_0000; frame[1] = 32'hC000_0000;
    frame[W] = 32'h3F00_0000; frame[W+1] = 32'h8000_0000;
    build_expected();
    drive_pixels(NPIX, 2);
    for (int i = 0; i < NPIX; i++) frame[i] = $urandom();
    frame[0] = 32'hBF80_0000; frame[1] = 32'hC000_0000;
    frame[W] = 32'hC040_0000; frame[W+1] = 32'hC080_0000;
    build_expected();
    drive_pixels(NPIX, 2);
    ready_mode = 0;
    wait_outputs(2 * NOUT);
    n_checks++;
    if (cap_r.size() !== 2 * NOUT) begin n_fail++; $display("FAIL win_count: got %0d want %0d", cap_r.size(), 2 * NOUT); end
    if (cap_r.size() == 2 * NOUT) begin
      n_checks += 4;
      if (cap_r[0] !== 32'h3F00_0000)    begin n_fail++; $display("FAIL win_a_relu: got %h want 3f000000", cap_r[0]); end
      if (cap_n[0] !== 32'h3F00_0000)    begin n_fail++; $display("FAIL win_a_norelu: got %h want 3f000000", cap_n[0]); end
      if (cap_r[NOUT] !== 32'h0)         begin n_fail++; $display("FAIL win_b_relu: got %h want 00000000", cap_r[NOUT]); end
      if (cap_n[NOUT] !== 32'hBF80_0000) begin n_fail++; $display("FAIL win_b_norelu: got %h want bf800000", cap_n[NOUT]); end
    end
    for (int k = 0; k < cap_r.size() && k < 2 * NOUT; k++) begin
      n_checks += 3;
      if (cap_r[k] !== exp_r[k]) begin n_fail++; $display("FAIL win_relu[%0d]: got %h want %h", k, cap_r[k], exp_r[k]); end
      if (cap_n[k] !== exp_n[k]) begin n_fail++; $display("FAIL win_norelu[%0d]: got %h want %h", k, cap_n[k], exp_n[k]); end
      if (cap_l[k] !== ((k % NOUT) == NOUT - 1)) begin n_fail++; $display("FAIL win_last[%0d]: got %b", k, cap_l[k]); end
    end
  endtask

  task automatic test_ramp();
    logic [31:0] want;
    clear_queues();
    ready_mode = 1;
    for (int i = 0; i < NPIX; i++) frame[i] = int2f(i);
    drive_pixels(NPIX, 1);
    ready_mode = 0;
    wait_outputs(NOUT);
    n_checks++;
    if (cap_r.size() !== NOUT) begin n_fail++; $display("FAIL ramp_count: got %0d want %0d", cap_r.size(), NOUT); end
    if (cap_r.size() > 0) begin
      n_checks++;
      if (cap_r[0] !== 32'h41E8_0000) begin n_fail++; $display("FAIL ramp_first: got %h want 41e80000", cap_r[0]); end
    end
    for (int k = 0; k < cap_r.size() && k < NOUT; k++) begin
      want = int2f((2 * (k / (W / 2)) + 1) * W + 2 * (k % (W / 2)) + 1);
      n_checks += 2;
      if (cap_r[k] !== want) begin n_fail++; $display("FAIL ramp_relu[%0d]: got %h want %h", k, cap_r[k], want); end
      if (cap_n[k] !== want) begin n_fail++; $display("FAIL ramp_norelu[%0d]: got %h want %h", k, cap_n[k], want); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int t;
    clear_queues();
    ready_mode = 0;
    for (int i = 0; i < NPIX; i++) frame[i] = $urandom();
    build_expected();
    fork
      drive_pixels(NPIX, 0);
      begin
        repeat (300) @(negedge clk);
        ready_mode = 2;
        @(posedge clk); #2;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
        held = out_data;
        repeat (10) begin
          @(negedge clk);
          n_checks += 2;
          if (out_data !== held) begin n_fail++; $display("FAIL bp_stable: got %h want %h", out_data, held); end
          if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        end
        ready_mode = 0;
      end
    join
    wait_outputs(NOUT);
    n_checks++;
    if (cap_r.size() !== NOUT) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", cap_r.size(), NOUT); end
    for (int k = 0; k < cap_r.size() && k < NOUT; k++) begin
      n_checks += 2;
      if (cap_r[k] !== exp_r[k]) begin n_fail++; $display("FAIL bp_relu[%0d]: got %h want %h", k, cap_r[k], exp_r[k]); end
      if (cap_n[k] !== exp_n[k]) begin n_fail++; $display("FAIL bp_norelu[%0d]: got %h want %h", k, cap_n[k], exp_n[k]); end
    end
  endtask

  task automatic test_reset_midframe();
    ready_mode = 0;
    for (int i = 0; i < NPIX; i++) frame[i] = $urandom();
    drive_pixels(100, 0);
    reset = 1'b0;
    #2;
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    if (out_last !== 1'b0)  begin n_fail++; $display("FAIL midrst_out_last: got %b want 0", out_last); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    clear_queues();
    for (int i = 0; i < NPIX; i++) frame[i] = 32'h43C8_0000;
    drive_pixels(NPIX, 0);
    wait_outputs(NOUT);
    n_checks++;
    if (cap_r.size() !== NOUT) begin n_fail++; $display("FAIL midrst_count: got %0d want %0d", cap_r.size(), NOUT); end
    for (int k = 0; k < cap_r.size() && k < NOUT; k++) begin
      n_checks += 2;
      if (cap_r[k] !== 32'h43C8_0000) begin n_fail++; $display("FAIL midrst_data[%0d]: got %h want 43c80000", k, cap_r[k]); end
      if (cap_l[k] !== (k == NOUT - 1)) begin n_fail++; $display("FAIL midrst_last[%0d]: got %b want %b", k, cap_l[k], k == NOUT - 1); end
    end
  endtask

  initial begin
    test_reset();
    test_const_frame();
    test_windows();
    test_ramp();
    test_backpressure();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
